// File: rtl/instr_fetch_unit.sv
// Two-beat instruction fetch: assembles a big-endian 16-bit instruction from a
// byte-wide memory and stalls the PC until the instruction is complete.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_next,
  input  logic        advance,
  input  logic        flush,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_VALID = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc_s;
  logic [15:0] instr_q, instr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        instr_valid_q, instr_valid_d;
  logic        stall_q, stall_d;
  logic        fault_q, fault_d;

  // Next-state, wait counter and captured bytes; flush overrides any beat.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    cnt_inc_s  = cnt_q + 8'd1;
    if (flush) begin
      state_d    = S_HI;
      fetch_pc_d = pc_next;
      cnt_d      = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_HI;
        S_HI: begin
          if (mem_ready) begin
            instr_d[15:8] = mem_rdata;
            cnt_d         = 8'd0;
            state_d       = S_LO;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            cnt_d   = cnt_inc_s;
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_LO: begin
          if (mem_ready) begin
            instr_d[7:0] = mem_rdata;
            cnt_d        = 8'd0;
            state_d      = S_VALID;
          end else if (cnt_inc_s == TIMEOUT_C) begin
            cnt_d   = cnt_inc_s;
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end
        S_VALID: begin
          if (advance) begin
            fetch_pc_d = pc_next;
            state_d    = S_HI;
          end else begin
            state_d = S_VALID;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are precomputed from the next state so they leave straight from flops.
  always_comb begin
    mem_rd_d      = (state_d == S_HI) || (state_d == S_LO);
    instr_valid_d = (state_d == S_VALID);
    fault_d       = (state_d == S_FAULT);
    stall_d       = ~instr_valid_d;
    case (state_d)
      S_HI:    mem_addr_d = fetch_pc_d;
      S_LO:    mem_addr_d = fetch_pc_d + 16'd1;
      default: mem_addr_d = mem_addr_q;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      cnt_q         <= 8'd0;
      instr_q       <= 16'h0000;
      mem_addr_q    <= 16'h0000;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      stall_q       <= 1'b1;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      instr_valid_q <= instr_valid_d;
      stall_q       <= stall_d;
      fault_q       <= fault_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign stall       = stall_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table followed by
// hand-written timeout, flush-from-fault and mid-fetch reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_next;
  logic        advance;
  logic        flush;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .advance(advance),
    .flush(flush), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h12;
      16'h0001: return 8'h34;
      16'h0040: return 8'hAB;
      16'h0041: return 8'hCD;
      16'h0100: return 8'h77;
      16'h0101: return 8'h88;
      16'h0200: return 8'hC3;
      16'h0201: return 8'h3C;
      16'hFFFF: return 8'h5A;
      default:  return 8'hEE;
    endcase
  endfunction

  assign mem_rdata = mem_byte(mem_addr);

  typedef struct {
    logic        flush;
    logic        adv;
    logic [15:0] pc;
    logic        rdy;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_val;
    logic        chk_instr;
    logic [15:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic f, input logic a, input logic [15:0] p, input logic r,
                     input logic erd, input logic [15:0] eaddr, input logic ev,
                     input logic ci, input logic [15:0] ei);
    vec_t v;
    v.flush = f; v.adv = a; v.pc = p; v.rdy = r;
    v.e_rd = erd; v.e_addr = eaddr; v.e_val = ev; v.chk_instr = ci; v.e_instr = ei;
    vecs.push_back(v);
  endtask

  task automatic step(input logic f, input logic a, input logic [15:0] p, input logic r);
    flush = f; advance = a; pc_next = p; mem_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_rd"},   {15'd0, mem_rd},      16'd0);
    check({tag, "_mem_addr"}, mem_addr,             16'h0000);
    check({tag, "_instr"},    instr,                16'h0000);
    check({tag, "_valid"},    {15'd0, instr_valid}, 16'd0);
    check({tag, "_stall"},    {15'd0, stall},       16'd1);
    check({tag, "_fault"},    {15'd0, fault},       16'd0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; advance = 1'b0; pc_next = 16'h0000; mem_ready = 1'b0;

    //   flush adv  pc_next   rdy | rd  addr      valid chk instr
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000); // IDLE->HI
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000); // HI->LO
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h1234); // VALID on cycle 3
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h1234); // held
    add(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000); // advance
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0041, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0041, 1'b1, 1'b1, 16'hABCD);
    add(1'b0, 1'b1, 16'h0200, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000); // wait states
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000); // advance ignored in HI
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0201, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0201, 1'b1, 1'b1, 16'hC33C);
    add(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000); // wrap
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h5A12);
    add(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000); // flush in LO
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0041, 1'b0, 1'b0, 16'h0000);
    add(1'b1, 1'b0, 16'h0100, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 16'h0000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0101, 1'b1, 1'b1, 16'h7788);

    #12;
    check_reset_values("reset");
    #5 reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].flush, vecs[i].adv, vecs[i].pc, vecs[i].rdy);
      check($sformatf("v%0d_mem_rd", i),   {15'd0, mem_rd},      {15'd0, vecs[i].e_rd});
      check($sformatf("v%0d_mem_addr", i), mem_addr,             vecs[i].e_addr);
      check($sformatf("v%0d_valid", i),    {15'd0, instr_valid}, {15'd0, vecs[i].e_val});
      check($sformatf("v%0d_stall", i),    {15'd0, stall},       {15'd0, ~vecs[i].e_val});
      check($sformatf("v%0d_fault", i),    {15'd0, fault},       16'd0);
      if (vecs[i].chk_instr) check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
    end

    // Timeout in HI: 14 wait cycles are tolerated, the 15th faults.
    step(1'b0, 1'b1, 16'h0300, 1'b0);
    check("to_start_addr", mem_addr, 16'h0300);
    for (int k = 1; k <= 14; k++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      check($sformatf("to_wait%0d_fault", k), {15'd0, fault},  16'd0);
      check($sformatf("to_wait%0d_rd", k),    {15'd0, mem_rd}, 16'd1);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    check("to_fault",       {15'd0, fault},       16'd1);
    check("to_fault_rd",    {15'd0, mem_rd},      16'd0);
    check("to_fault_valid", {15'd0, instr_valid}, 16'd0);
    check("to_fault_stall", {15'd0, stall},       16'd1);
    step(1'b0, 1'b1, 16'h0040, 1'b1);
    step(1'b0, 1'b1, 16'h0040, 1'b1);
    check("fault_sticky",    {15'd0, fault},  16'd1);
    check("fault_sticky_rd", {15'd0, mem_rd}, 16'd0);

    // Flush leaves FAULT and restarts at pc_next.
    step(1'b1, 1'b0, 16'h0040, 1'b1);
    check("flush_clr_fault", {15'd0, fault},  16'd0);
    check("flush_rd",        {15'd0, mem_rd}, 16'd1);
    check("flush_addr",      mem_addr,        16'h0040);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("flush_lo_addr", mem_addr, 16'h0041);

    // Asynchronous reset in the middle of the LO beat.
    #3 reset = 1'b0;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    check_reset_values("midrst_hold");
    #2 reset = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("rst_hi_addr", mem_addr, 16'h0000);
    check("rst_hi_rd",   {15'd0, mem_rd}, 16'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("rst_refetch_valid", {15'd0, instr_valid}, 16'd1);
    check("rst_refetch_instr", instr, 16'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
